// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Holds the machine word type plus the instruction-cache frame, default
// geometry and controller state encoding used by icache_ctrl.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default number of direct-mapped frames.
  localparam int unsigned ICACHE_SETS = 16;

  // Widest tag any legal geometry needs (SETS=2 leaves 32-2-1 tag bits).
  localparam int unsigned ICACHE_TAG_W = 29;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_stats.sv
// Hit / miss event counters for the instruction cache.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   hit_i               one cycle per cache hit
//   miss_i              one cycle per miss (IDLE->FETCH transition)
//   hit_count_o         running hit total, wraps modulo 2^32
//   miss_count_o        running miss total, wraps modulo 2^32
module icache_stats
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  hit_i,
  input  logic  miss_i,
  output word_t hit_count_o,
  output word_t miss_count_o
);

  word_t hit_q, hit_d;
  word_t miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q + word_t'(hit_i);
    miss_d = miss_q + word_t'(miss_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-block instruction cache controller.
// Hits return data combinationally; a miss issues a single-word read to the
// memory controller, fills the frame when iwait drops and hits next cycle.
// Optional feature macro: ICACHE_STATS_EN enables the hit/miss counters;
// when undefined both counter outputs are tied to zero.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   imemREN, imemaddr   fetch request and byte address
//   flush               invalidate all frames
//   ihit, imemload      hit flag and instruction to fetch stage
//   iREN, iaddr         read request / word address to memory controller
//   iwait, iload        memory busy flag and returned instruction
//   hit_count           number of hits (stats build only)
//   miss_count          number of misses (stats build only)
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = ICACHE_SETS
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  flush,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TagW = 30 - IDX;

  icache_state_t   state_q, state_d;
  logic [29:0]     miss_q, miss_d;  // word address of the outstanding miss
  logic [SETS-1:0] valid_q, valid_d;
  logic [TagW-1:0] tag_q [SETS];
  word_t           data_q [SETS];

  logic [IDX-1:0]  req_idx, fill_idx;
  logic [TagW-1:0] req_tag, fill_tag;
  icache_frame_t   req_frame;
  logic            hit;
  logic            fill_en;
  logic            unused_byte_off;

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = miss_q[IDX-1:0];
  assign fill_tag = miss_q[29:IDX];
  assign unused_byte_off = ^imemaddr[1:0];

  assign req_frame = '{valid: valid_q[req_idx],
                       tag:   ICACHE_TAG_W'(tag_q[req_idx]),
                       data:  data_q[req_idx]};
  assign hit = imemREN & req_frame.valid & (req_frame.tag == ICACHE_TAG_W'(req_tag));

  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    fill_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = req_frame.data;
        end else if (imemREN) begin
          miss_d  = imemaddr[31:2];
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Request address is frozen in miss_q; fetch-stage changes are ignored.
        iREN  = 1'b1;
        iaddr = {miss_q, 2'b00};
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush takes priority over a coinciding fill so no stale frame survives.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic miss_start;
  assign miss_start = (state_q == IDLE) & imemREN & ~hit;

  icache_stats u_stats (
    .clk_i        (CLK),
    .rst_i        (RST),
    .hit_i        (ihit),
    .miss_i       (miss_start),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl (SETS=16).
// Table of per-cycle vectors with hand-computed outputs, followed by
// hand-written reset sequences.
module tb_icache_ctrl;
  import cpu_types_pkg::*;

`ifdef ICACHE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  imemREN = 1'b0;
  word_t imemaddr = '0;
  logic  flush = 1'b0;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait = 1'b1;
  word_t iload = '0;
  word_t hit_count;
  word_t miss_count;

  icache_ctrl #(.SETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ren;
    word_t addr;
    logic  flush;
    logic  iwait;
    word_t iload;
    logic  e_hit;
    word_t e_load;
    logic  e_iren;
    word_t e_iaddr;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   m_hits = 0;
  int   m_misses = 0;

  task automatic add(input logic r, input word_t a, input logic f, input logic w,
                     input word_t l, input logic eh, input word_t el, input logic er,
                     input word_t ea);
    vec_t v;
    v = '{ren: r, addr: a, flush: f, iwait: w, iload: l,
          e_hit: eh, e_load: el, e_iren: er, e_iaddr: ea};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t cnt_exp(input int n);
    return StatsEn ? word_t'(n) : '0;
  endfunction

  task automatic check_all(input string tag, input logic eh, input word_t el,
                           input logic er, input word_t ea);
    check({tag, " ihit"}, word_t'(ihit), word_t'(eh));
    check({tag, " imemload"}, imemload, el);
    check({tag, " iREN"}, word_t'(iREN), word_t'(er));
    check({tag, " iaddr"}, iaddr, ea);
    check({tag, " hit_count"}, hit_count, cnt_exp(m_hits));
    check({tag, " miss_count"}, miss_count, cnt_exp(m_misses));
  endtask

  localparam word_t D40 = 32'h8C01_0004;

  initial begin
    // r  addr      fl w  iload         hit data  iREN iaddr
    // Cold miss on 0x40, iwait high three cycles.
    add(0, 32'h040, 0, 1, 32'h0,        0, 32'h0, 0, 32'h0);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 0, 32'h0);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 0, D40,          0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 1, 32'h0,        1, D40,   0, 32'h0);
    add(1, 32'h042, 0, 1, 32'h0,        1, D40,   0, 32'h0);
    add(1, 32'h040, 0, 1, 32'h0,        1, D40,   0, 32'h0);
    // Conflict at index 0: 0x80 evicts 0x40, then 0x40 refetched.
    add(1, 32'h080, 0, 0, 32'h1111_1111, 0, 32'h0, 0, 32'h0);
    add(1, 32'h080, 0, 0, 32'h1111_1111, 0, 32'h0, 1, 32'h080);
    add(1, 32'h040, 0, 0, D40,          0, 32'h0, 0, 32'h0);
    add(1, 32'h040, 0, 0, D40,          0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 1, 32'h0,        1, D40,   0, 32'h0);
    // Evict 0x40 again, then change address mid-fetch.
    add(1, 32'h080, 0, 0, 32'h2222_2222, 0, 32'h0, 0, 32'h0);
    add(1, 32'h080, 0, 0, 32'h2222_2222, 0, 32'h0, 1, 32'h080);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 0, 32'h0);
    add(1, 32'h100, 0, 1, 32'h0,        0, 32'h0, 1, 32'h040);
    add(1, 32'h100, 0, 0, 32'h3333_3333, 0, 32'h0, 1, 32'h040);
    add(1, 32'h100, 0, 0, 32'h4444_4444, 0, 32'h0, 0, 32'h0);
    add(1, 32'h100, 0, 0, 32'h4444_4444, 0, 32'h0, 1, 32'h100);
    add(1, 32'h100, 0, 1, 32'h0,        1, 32'h4444_4444, 0, 32'h0);
    // Flush coinciding with the fill of 0x40; 0x44 was valid before.
    add(1, 32'h044, 0, 0, 32'h5555_5555, 0, 32'h0, 0, 32'h0);
    add(1, 32'h044, 0, 0, 32'h5555_5555, 0, 32'h0, 1, 32'h044);
    add(1, 32'h044, 0, 1, 32'h0,        1, 32'h5555_5555, 0, 32'h0);
    add(1, 32'h040, 0, 1, 32'h0,        0, 32'h0, 0, 32'h0);
    add(1, 32'h040, 1, 0, D40,          0, 32'h0, 1, 32'h040);
    add(1, 32'h040, 0, 0, D40,          0, 32'h0, 0, 32'h0);
    add(1, 32'h040, 0, 0, D40,          0, 32'h0, 1, 32'h040);
    add(1, 32'h044, 0, 0, 32'h5555_5555, 0, 32'h0, 0, 32'h0);
    add(1, 32'h044, 0, 0, 32'h5555_5555, 0, 32'h0, 1, 32'h044);
    add(1, 32'h044, 0, 1, 32'h0,        1, 32'h5555_5555, 0, 32'h0);
    add(1, 32'h040, 0, 1, 32'h0,        1, D40,   0, 32'h0);
    // No request: outputs idle even though 0x40 would hit.
    add(0, 32'h040, 0, 1, 32'h0,        0, 32'h0, 0, 32'h0);

    // Reset state while RST held.
    #2;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      flush    = vecs[i].flush;
      iwait    = vecs[i].iwait;
      iload    = vecs[i].iload;
      @(negedge CLK);
      check_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load,
                vecs[i].e_iren, vecs[i].e_iaddr);
      if (vecs[i].e_hit) m_hits++;
      if (vecs[i].ren && !vecs[i].e_hit && !vecs[i].e_iren) m_misses++;
      @(posedge CLK);
      #1;
    end

    // Reset pulsed mid-FETCH of 0x48.
    imemREN  = 1'b1;
    imemaddr = 32'h048;
    flush    = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h6666_6666;
    @(posedge CLK);
    #1;
    check("rst_mid pre iREN", word_t'(iREN), 32'h1);
    check("rst_mid pre iaddr", iaddr, 32'h048);
    #2;
    RST = 1'b1;
    #1;
    m_hits   = 0;
    m_misses = 0;
    check_all("rst_mid async", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    // 0x48 was never filled and 0x44 was invalidated by reset: both miss.
    check_all("rst_mid 0x48 miss", 1'b0, 32'h0, 1'b0, 32'h0);
    m_misses++;
    @(posedge CLK);
    #1;
    iwait = 1'b0;
    check("rst_mid refetch iREN", word_t'(iREN), 32'h1);
    check("rst_mid refetch iaddr", iaddr, 32'h048);
    @(posedge CLK);
    #1;
    iwait    = 1'b1;
    imemaddr = 32'h044;
    @(negedge CLK);
    check_all("rst_mid 0x44 miss", 1'b0, 32'h0, 1'b0, 32'h0);
    m_misses++;
    @(posedge CLK);
    #1;
    imemaddr = 32'h048;
    iwait    = 1'b0;
    iload    = 32'h7777_7777;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_all("rst_mid 0x48 hit", 1'b1, 32'h6666_6666, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
